// File: rtl/ahb_mem_backend.sv
// ---------------------------------------------------------------------------
// ahb_mem_backend
//
// Purpose:
//   Memory back end behind the generic AHB slave interface. It takes the
//   rd_en/wr_en/address/wr_data strobes from the interface and answers with
//   rd_data/ready/error. The storage is a word-addressed on-chip memory. A
//   configurable number of wait states can be inserted before a good
//   completion. Misaligned, below-base and beyond-end accesses get the
//   two-cycle AHB ERROR response on the ready/error pair.
//
// Optional feature:
//   SLAVE_MEM_WP_EN - when defined, adds the wp input. A write accepted while
//                     wp=1 is refused with an ERROR response and does not
//                     change memory. Reads are not affected by wp.
//
// Parameters:
//   DATA_WIDTH  - data bus width, must be 32
//   ADDR_WIDTH  - byte address width
//   MEM_DEPTH   - number of 32-bit words (power of 2, >= 2)
//   BASE_ADDR   - byte address of word 0
//   WAIT_STATES - cycles with ready low before a good completion (0..15)
//
// Ports:
//   HCLK     in   clock
//   HRESETn  in   asynchronous active-low reset
//   rd_en    in   read request for the current address
//   wr_en    in   write request for the current address/wr_data
//   address  in   byte address
//   wr_data  in   write data
//   wp       in   write protect (only with SLAVE_MEM_WP_EN)
//   rd_data  out  read data, valid while ready=1 in a read completion cycle
//   ready    out  transfer complete / able to accept
//   error    out  error response
// ---------------------------------------------------------------------------
module ahb_mem_backend #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wr_data,
`ifdef SLAVE_MEM_WP_EN
  input  logic                  wp,
`endif
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ready,
  output logic                  error
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    ERR2 = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // State and latched request
  // -------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   rd_q, rd_d;

  // Storage. Never reset: the contents survive HRESETn.
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  logic                    req;
  logic                    req_wr;
  logic [ADDR_WIDTH-1:0]   idx_full;
  logic [IDX_W-1:0]        cur_idx;
  logic                    bad_addr;
  logic                    wp_hit;
  logic                    bad;

  assign req    = rd_en | wr_en;
  // When both strobes are high, the request is a write.
  assign req_wr = wr_en;

  // Keep the full-width word index so that an access far beyond the end is
  // caught by the range compare instead of aliasing onto a low word.
  assign idx_full = (address - BASE_ADDR) >> 2;
  assign cur_idx  = idx_full[IDX_W-1:0];

  assign bad_addr = (address[1:0] != 2'b00)
                 || (address < BASE_ADDR)
                 || (idx_full >= ADDR_WIDTH'(MEM_DEPTH));

`ifdef SLAVE_MEM_WP_EN
  assign wp_hit = wr_en & wp;
`else
  assign wp_hit = 1'b0;
`endif

  assign bad = bad_addr | wp_hit;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = cur_idx;
          wdata_d = wr_data;
          wr_d    = req_wr;
          if (bad) begin
            state_d = ERR2;
          end else if (WAIT_STATES == 0) begin
            // Zero-latency completion: the transfer ends in this cycle.
            state_d = IDLE;
          end else begin
            // The request cycle is the first ready-low cycle, so WAIT
            // covers only the remaining WAIT_STATES-1 cycles.
            cnt_d   = 4'(WAIT_STATES - 1);
            state_d = (WAIT_STATES == 1) ? DONE : WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      ERR2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data is captured on the edge that enters DONE. For WAIT_STATES=1
  // that edge comes straight from IDLE, so the index is taken from the
  // live address in that case.
  always_comb begin
    rd_d = rd_q;
    if ((state_d == DONE) && (state_q != DONE)) begin
      if (state_q == IDLE) begin
        if (!req_wr) begin
          rd_d = mem[cur_idx];
        end
      end else if (!wr_q) begin
        rd_d = mem[idx_q];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // -------------------------------------------------------------------------
  // Memory write port
  // -------------------------------------------------------------------------
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_widx;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = idx_q;
    mem_wdata = wdata_q;
    if ((state_q == IDLE) && req && !bad && req_wr && (WAIT_STATES == 0)) begin
      mem_we    = 1'b1;
      mem_widx  = cur_idx;
      mem_wdata = wr_data;
    end else if ((state_q == DONE) && wr_q) begin
      mem_we = 1'b1;
    end
    // A write that is pending while reset is held must be dropped.
    mem_we = mem_we & HRESETn;
  end

  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Response outputs
  // -------------------------------------------------------------------------
  // The IDLE response depends on the request in the same cycle. This is
  // what lets a zero-wait transfer complete immediately and lets a bad
  // request start ERROR at once, so the read in that case is asynchronous.
  always_comb begin
    ready   = 1'b1;
    error   = 1'b0;
    rd_data = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (bad) begin
            ready = 1'b0;
            error = 1'b1;
          end else if (WAIT_STATES != 0) begin
            ready = 1'b0;
          end else if (!req_wr) begin
            rd_data = mem[cur_idx];
          end
        end
      end
      WAIT: ready = 1'b0;
      DONE: rd_data = wr_q ? '0 : rd_q;
      ERR2: error = 1'b1;
      default: begin
        ready = 1'b1;
        error = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/ahb_mem_backend.md
Name: ahb_mem_backend

Overview:
- Downstream stage of the generic AHB slave interface: consumes its rd_en/wr_en/address/wr_data strobes and returns rd_data/ready/error.
- Implements a word-addressed on-chip memory with a configurable number of wait states.
- Performs address range and alignment checks, and generates the two-cycle AHB ERROR handshake on the ready/error pair.

Parameters:
- DATA_WIDTH, 32, data bus width (must be 32).
- ADDR_WIDTH, 32, address width.
- MEM_DEPTH, 256, number of 32-bit words (power of 2, >= 2).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_STATES, 0, cycles with ready low before a good completion (0..15).

Ports:
- HCLK  input  1  clock
- HRESETn  input  1  asynchronous active-low reset
- rd_en  input  1  read request for current address
- wr_en  input  1  write request for current address/wr_data
- address  input  ADDR_WIDTH  byte address
- wr_data  input  DATA_WIDTH  write data
- rd_data  output  DATA_WIDTH  read data, valid when ready=1 in a read completion cycle
- ready  output  1  transfer complete / able to accept
- error  output  1  error response
- wp  input  1  write protect (present only with SLAVE_MEM_WP_EN)

Behaviour:
- Reset: HRESETn is asynchronous, active-low; clock is HCLK. On reset: state=IDLE, ready=1, error=0, rd_data=0, wait counter=0. Memory contents are not reset. Reset asserted mid-transfer abandons the transfer; a write not yet committed is dropped.
- Request: req = rd_en | wr_en, sampled only in IDLE. If both are high, the request is treated as a write.
- Request latching: on acceptance, latch address, wr_data and direction. Inputs are ignored until the FSM returns to IDLE.
- Index: idx = (address - BASE_ADDR) >> 2.
- Bad access: the access is bad if address[1:0] != 0, address < BASE_ADDR, or idx >= MEM_DEPTH. Uses full ADDR_WIDTH unsigned compare; no wrap-around.
- State IDLE:
  - No req: ready=1, error=0, rd_data=0.
  - Bad req: ready=0, error=1, go to ERR2.
  - Good req, WAIT_STATES=0: zero-latency completion. ready=1, error=0, rd_data=mem[idx] combinationally for reads; a write commits at this clock edge. Stay IDLE.
  - Good req, WAIT_STATES>0: ready=0, cnt<=WAIT_STATES-1, go to WAIT (if WAIT_STATES=1, go straight to DONE).
- State WAIT: ready=0, error=0. Decrement cnt; when cnt=1 go to DONE. Read data is captured into rd_q on the WAIT->DONE edge.
- State DONE: ready=1, error=0, rd_data=rd_q for reads, 0 for writes. The write commits at the DONE clock edge. Go to IDLE.
- State ERR2: ready=1, error=1, rd_data=0. Go to IDLE. No memory access occurs in either error cycle.
- Timing: a good access holds ready low for exactly WAIT_STATES cycles, starting at the request cycle; completion follows in the next cycle.
- Back-to-back: a new request is accepted in the first IDLE cycle after DONE/ERR2. A request persisting in the same cycle as completion (zero-wait) is a new transfer on the next cycle.
- Write then read of the same word: the read returns the new data. This holds with no extra hazard logic because the write commits before any subsequent read samples memory.
- error is never asserted with ready=1 except in ERR2.

Optional Feature:
- Macro: SLAVE_MEM_WP_EN.
- Defined: wp port exists. A write accepted while wp=1 is treated as a bad access: two-cycle ERROR (IDLE->ERR2), memory unchanged. Reads are unaffected.
- Undefined: no wp port; writes are never protected.

Test Plan:
- WAIT_STATES=0: write 32'hDEAD_BEEF to 0x10, then read 0x10 -> ready stays 1 both cycles, rd_data=32'hDEAD_BEEF in the read cycle, error=0.
- WAIT_STATES=3: read of 0x04 holding 32'h1234_5678 -> ready=0 for 3 cycles from the request cycle, then 1 cycle ready=1 with rd_data=32'h1234_5678, then IDLE.
- Misaligned write to 0x06 and out-of-range read at BASE_ADDR+MEM_DEPTH*4 -> each gives ready=0/error=1 then ready=1/error=1; memory unchanged; the next request is serviced normally.
- Back-to-back: WAIT_STATES=2, write 0x20=32'hA5A5_A5A5, then immediately read 0x20 -> the read completes with 32'hA5A5_A5A5, 3 cycles per transfer.
- Reset during WAIT of a write to 0x08 (old value 32'h0) -> ready=1, error=0 immediately; a subsequent read of 0x08 returns 32'h0.
- SLAVE_MEM_WP_EN defined, wp=1: write 32'hFFFF_FFFF to 0x00 -> ERROR response; read 0x00 returns the prior value. With wp=0 the write succeeds.
